mem_access_ctrl: RTL

- Upstream sequencer for the LC-3b memory block. Accepts one load/store request at a time from the datapath/microsequencer and drives the memory's MAR/MDR load strobes, rw, datasize and 16-bit bus.
- Waits for the memory-ready flag, then returns read data or a completion/error response.
- Adds alignment checking and a ready-timeout, so a stalled memory cannot hang the core.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_timeout_cnt.sv | 28 ++
 rtl/mem_access_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the LC-3b memory path: sequencer states, access size/direction codes
// and the default ready-timeout.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A_LOAD,
        A_SETTLE,
        A_WAIT,
        D_LOAD,
        D_SETTLE,
        D_WAIT,
        RESP
    } mem_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 32;
    localparam int unsigned CNT_W           = 8;

    localparam logic BYTE  = 1'b1;
    localparam logic WORD  = 1'b0;
    localparam logic WRITE = 1'b1;
    localparam logic READ  = 1'b0;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Loadable 8-bit down-counter that bounds each wait-for-ready phase.
module mem_timeout_cnt
    import mem_pkg::*;
(
    input  logic             clk_50,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt;

    // Saturates at zero so a stalled wait phase keeps reporting expiry.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store sequencer in front of the LC-3b memory: drives MAR/MDR
// strobes, rw and datasize, waits on mem_r with a timeout, and returns a one-cycle response.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned AW      = 16
) (
    input  logic          clk_50,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic          req_byte,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [AW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [AW-1:0] mem_bus,
    output logic          mem_ldMar,
    output logic          mem_ldMdr,
    output logic          mem_rw,
    output logic          mem_datasize,
    input  logic          mem_r,
    input  logic [AW-1:0] mem_mdr
);

    // The counter is checked for zero one cycle after its last decrement, so loading
    // TIMEOUT-1 gives exactly TIMEOUT cycles in a wait state before expiry.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

    mem_state_e    state;
    logic [AW-1:0] wdata_q;
    logic          we_q;
    logic          cnt_zero_c;

    mem_timeout_cnt u_timeout_cnt (
        .clk_50   (clk_50),
        .rst_n    (rst_n),
        .load     ((state == A_SETTLE) || (state == D_SETTLE)),
        .dec      ((state == A_WAIT) || (state == D_WAIT)),
        .load_val (CNT_LOAD),
        .zero_c   (cnt_zero_c)
    );

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wdata_q      <= '0;
            we_q         <= READ;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            mem_bus      <= '0;
            mem_ldMar    <= 1'b0;
            mem_ldMdr    <= 1'b0;
            mem_rw       <= READ;
            mem_datasize <= WORD;
        end else begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            mem_ldMar <= 1'b0;
            mem_ldMdr <= 1'b0;

            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready    <= 1'b0;
                        wdata_q      <= req_wdata;
                        we_q         <= req_we;
                        mem_datasize <= req_byte;
                        // Misaligned word access is answered without touching memory.
                        if ((req_byte == WORD) && req_addr[0]) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            state     <= A_LOAD;
                            mem_ldMar <= 1'b1;
                            mem_bus   <= req_addr;
                            mem_rw    <= READ;
                        end
                    end
                end
                A_LOAD:   state <= A_SETTLE;
                A_SETTLE: state <= A_WAIT;
                A_WAIT: begin
                    if (mem_r) begin
                        if (we_q == WRITE) begin
                            state     <= D_LOAD;
                            mem_ldMdr <= 1'b1;
                            mem_rw    <= WRITE;
                            mem_bus   <= (mem_datasize == BYTE) ? AW'(wdata_q[7:0]) : wdata_q;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_data  <= mem_mdr;
                        end
                    end else if (cnt_zero_c) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                    end
                end
                D_LOAD:   state <= D_SETTLE;
                D_SETTLE: state <= D_WAIT;
                D_WAIT: begin
                    if (mem_r || cnt_zero_c) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ~mem_r;
                        rsp_data  <= '0;
                        mem_rw    <= READ;
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    req_ready    <= 1'b1;
                    mem_datasize <= WORD;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
